// File: rtl/tcam_match_resolver_if.sv
// Handshake bundle between the TCAM match array, the match resolver and the
// result/action lookup stage.
interface tcam_match_resolver_if #(
  parameter int N     = 16,
  parameter int IDX_W = $clog2(N),
  parameter int CNT_W = $clog2(N) + 1
);
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_match;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic             out_hit;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;
  logic [CNT_W-1:0] out_count;

  modport master (
    output in_valid, in_match, flush, out_ready,
    input  in_ready, out_valid, out_hit, out_idx, out_last, out_count
  );

  modport slave (
    input  in_valid, in_match, flush, out_ready,
    output in_ready, out_valid, out_hit, out_idx, out_last, out_count
  );
endinterface

// File: rtl/tcam_match_resolver.sv
// Multi-match priority resolver: takes one match-line vector per search and
// streams the set indices out highest-first, one beat per handshake.
module tcam_match_resolver #(
  parameter int N        = 16,
  parameter int IDX_W    = $clog2(N),
  parameter bit MODE_ALL = 1'b1,
  parameter int CNT_W    = $clog2(N) + 1
) (
  input logic                 clk,
  input logic                 rst_n,
  tcam_match_resolver_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  state_t           state;
  logic [N-1:0]     pending;
  logic [CNT_W-1:0] count;
  logic             nomatch;

  logic             accept;
  logic             beat;
  logic [CNT_W-1:0] in_pop;
  logic [N-1:0]     next_pending;

  function automatic logic [IDX_W-1:0] top_idx(input logic [N-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] popcount(input logic [N-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

  function automatic logic [N-1:0] clear_top(input logic [N-1:0] v);
    logic [N-1:0] mask;
    mask = '0;
    mask[top_idx(v)] = 1'b1;
    return v & ~mask;
  endfunction

  // in_ready is purely a function of state and flush, never of out_ready.
  assign bus.in_ready = (state == IDLE) && !bus.flush;
  assign accept       = bus.in_valid && bus.in_ready;
  assign beat         = bus.out_valid && bus.out_ready;

  // Popcount of the offered vector and the vector left after the current beat.
  always_comb begin
    in_pop       = popcount(bus.in_match);
    next_pending = clear_top(pending);
  end

  // Search FSM; the out_* registers always present the beat for the current pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      pending       <= '0;
      count         <= '0;
      nomatch       <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_hit   <= 1'b0;
      bus.out_idx   <= '0;
      bus.out_last  <= 1'b0;
      bus.out_count <= '0;
    end else if (bus.flush) begin
      state         <= IDLE;
      pending       <= '0;
      count         <= '0;
      nomatch       <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_hit   <= 1'b0;
      bus.out_idx   <= '0;
      bus.out_last  <= 1'b0;
      bus.out_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state         <= EMIT;
            pending       <= bus.in_match;
            count         <= in_pop;
            nomatch       <= (bus.in_match == '0);
            bus.out_valid <= 1'b1;
            bus.out_hit   <= (bus.in_match != '0);
            bus.out_idx   <= top_idx(bus.in_match);
            bus.out_last  <= (bus.in_match == '0) || !MODE_ALL || (in_pop == CNT_W'(1));
            bus.out_count <= in_pop;
          end
        end
        EMIT: begin
          if (beat) begin
            if (bus.out_last) begin
              state         <= IDLE;
              pending       <= '0;
              bus.out_valid <= 1'b0;
              bus.out_last  <= 1'b0;
            end else begin
              // Not last implies MODE_ALL with at least two bits left.
              pending       <= next_pending;
              bus.out_hit   <= !nomatch;
              bus.out_idx   <= top_idx(next_pending);
              bus.out_last  <= (popcount(next_pending) == CNT_W'(1));
              bus.out_count <= count;
            end
          end
        end
        default: begin
          state         <= IDLE;
          pending       <= '0;
          bus.out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tcam_match_resolver.sv
// Bench: two resolvers (emit-all and single-hit) driven in lockstep and checked
// each cycle against a queue-of-expected-beats model.
module tb_tcam_match_resolver;

  logic clk;
  logic rst_n;

  tcam_match_resolver_if #(.N(16)) a ();
  tcam_match_resolver_if #(.N(16)) b ();

  tcam_match_resolver #(.N(16), .MODE_ALL(1'b1)) dut_all (
    .clk(clk), .rst_n(rst_n), .bus(a)
  );
  tcam_match_resolver #(.N(16), .MODE_ALL(1'b0)) dut_one (
    .clk(clk), .rst_n(rst_n), .bus(b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       hit;
    logic [3:0] idx;
    logic       last;
  } beat_t;
  typedef beat_t beat_q_t[$];

  typedef struct {
    logic [15:0] m;
    int          beats;
    int          first;
    int          cnt;
  } vec_t;

  int      n_cmp = 0;
  int      n_bad = 0;
  beat_q_t qa, qb;
  int      ca, cb;
  int      obs_beats, obs_first, obs_cnt;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected beat list for one search, derived from the list of set bits.
  function automatic beat_q_t expand(input logic [15:0] m, input bit all);
    beat_q_t q;
    q = {};
    if (m == 16'h0000) begin
      q.push_back('{hit: 1'b0, idx: 4'd0, last: 1'b1});
    end else begin
      for (int i = 15; i >= 0; i--) begin
        if (m[i]) q.push_back('{hit: 1'b1, idx: 4'(i), last: 1'b0});
      end
      if (!all) q = q[0:0];
      q[q.size()-1].last = 1'b1;
    end
    return q;
  endfunction

  task automatic check_out(input string tag, input logic v, input logic h,
                           input logic [3:0] ix, input logic l, input logic [4:0] c,
                           input beat_q_t q, input int ec);
    chk({tag, ".out_valid"}, int'(v), int'(q.size() != 0));
    if (q.size() != 0) begin
      chk({tag, ".out_hit"},   int'(h),  int'(q[0].hit));
      chk({tag, ".out_idx"},   int'(ix), int'(q[0].idx));
      chk({tag, ".out_last"},  int'(l),  int'(q[0].last));
      chk({tag, ".out_count"}, int'(c),  ec);
    end
  endtask

  // One clock: drive inputs, check in_ready, advance models across the edge, check outputs.
  task automatic cycle(input logic iv, input logic [15:0] im, input logic fl, input logic ordy);
    logic acc_a, acc_b, bt_a, bt_b;
    a.in_valid = iv; a.in_match = im; a.flush = fl; a.out_ready = ordy;
    b.in_valid = iv; b.in_match = im; b.flush = fl; b.out_ready = ordy;
    #1;
    chk("all.in_ready", int'(a.in_ready), int'((qa.size() == 0) && !fl));
    chk("one.in_ready", int'(b.in_ready), int'((qb.size() == 0) && !fl));
    acc_a = iv && (qa.size() == 0) && !fl;
    acc_b = iv && (qb.size() == 0) && !fl;
    bt_a  = (qa.size() != 0) && ordy;
    bt_b  = (qb.size() != 0) && ordy;
    if (a.out_valid && ordy) begin
      if (obs_beats == 0) begin
        obs_first = int'(a.out_idx);
        obs_cnt   = int'(a.out_count);
      end
      obs_beats++;
    end
    @(posedge clk);
    #1;
    if (fl) qa.delete(); else if (bt_a) void'(qa.pop_front());
    if (fl) qb.delete(); else if (bt_b) void'(qb.pop_front());
    if (acc_a) begin qa = expand(im, 1'b1); ca = $countones(im); end
    if (acc_b) begin qb = expand(im, 1'b0); cb = $countones(im); end
    check_out("all", a.out_valid, a.out_hit, a.out_idx, a.out_last, a.out_count, qa, ca);
    check_out("one", b.out_valid, b.out_hit, b.out_idx, b.out_last, b.out_count, qb, cb);
  endtask

  task automatic drain();
    for (int t = 0; t < 60 && (qa.size() != 0 || qb.size() != 0); t++) cycle(1'b0, 16'h0000, 1'b0, 1'b1);
    chk("drain_timeout", int'(a.out_valid || b.out_valid), 0);
  endtask

  initial begin
    vec_t vecs[6];
    logic [15:0] rm;
    int exp_idx;

    vecs[0] = '{m: 16'h8421, beats: 4,  first: 15, cnt: 4};
    vecs[1] = '{m: 16'h0000, beats: 1,  first: 0,  cnt: 0};
    vecs[2] = '{m: 16'h0110, beats: 2,  first: 8,  cnt: 2};
    vecs[3] = '{m: 16'hFFFF, beats: 16, first: 15, cnt: 16};
    vecs[4] = '{m: 16'h0001, beats: 1,  first: 0,  cnt: 1};
    vecs[5] = '{m: 16'h8000, beats: 1,  first: 15, cnt: 1};

    rst_n = 1'b0;
    a.in_valid = 1'b0; a.in_match = 16'h0; a.flush = 1'b0; a.out_ready = 1'b0;
    b.in_valid = 1'b0; b.in_match = 16'h0; b.flush = 1'b0; b.out_ready = 1'b0;
    #2;
    chk("rst.out_valid", int'(a.out_valid), 0);
    chk("rst.out_hit",   int'(a.out_hit),   0);
    chk("rst.out_idx",   int'(a.out_idx),   0);
    chk("rst.out_last",  int'(a.out_last),  0);
    chk("rst.out_count", int'(a.out_count), 0);
    chk("rst.in_ready",  int'(a.in_ready),  1);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table: single search each, full throughput.
    for (int v = 0; v < 6; v++) begin
      obs_beats = 0; obs_first = -1; obs_cnt = -1;
      cycle(1'b1, vecs[v].m, 1'b0, 1'b1);
      drain();
      chk("tbl.beats", obs_beats, vecs[v].beats);
      chk("tbl.first", obs_first, vecs[v].first);
      chk("tbl.count", obs_cnt,   vecs[v].cnt);
    end

    // All-ones under a 1,0,0 backpressure pattern; in_valid held to prove no early accept.
    cycle(1'b1, 16'hFFFF, 1'b0, 1'b1);
    exp_idx = 15;
    for (int p = 0; p < 100 && qa.size() != 0; p++) begin
      if ((p % 3) == 0 && a.out_valid) begin
        chk("ffff.order", int'(a.out_idx), exp_idx);
        exp_idx--;
      end
      cycle(1'b1, 16'h0003, 1'b0, ((p % 3) == 0));
    end
    chk("ffff.beats", exp_idx, -1);
    drain();

    // Flush mid-stream, then a clean search.
    cycle(1'b1, 16'h00F0, 1'b0, 1'b1);
    cycle(1'b0, 16'h0000, 1'b0, 1'b1);
    cycle(1'b0, 16'h0000, 1'b0, 1'b1);
    cycle(1'b0, 16'h0000, 1'b1, 1'b0);
    chk("flush.out_valid", int'(a.out_valid), 0);
    cycle(1'b1, 16'h0002, 1'b0, 1'b0);
    chk("flush.new_idx",  int'(a.out_idx),  1);
    chk("flush.new_last", int'(a.out_last), 1);
    drain();

    // Async reset between edges mid-search.
    cycle(1'b1, 16'h0F00, 1'b0, 1'b1);
    cycle(1'b0, 16'h0000, 1'b0, 1'b1);
    a.in_valid = 1'b0; b.in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("arst.out_valid", int'(a.out_valid), 0);
    chk("arst.in_ready",  int'(a.in_ready),  1);
    qa.delete(); qb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    cycle(1'b1, 16'h0001, 1'b0, 1'b0);
    chk("arst.new_idx",  int'(a.out_idx),  0);
    chk("arst.new_hit",  int'(a.out_hit),  1);
    drain();

    // Randomized traffic.
    for (int r = 0; r < 3000; r++) begin
      case ($urandom_range(0, 3))
        0:       rm = 16'($urandom);
        1:       rm = 16'h0001 << $urandom_range(0, 15);
        2:       rm = 16'h0000;
        default: rm = 16'hFFFF;
      endcase
      cycle(($urandom_range(0, 1) == 1), rm, ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0));
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
